// File: rtl/network_rx_arbiter.sv
// ---------------------------------------------------------------------------
// network_rx_arbiter
//
// Shares one downstream input path between two network receive ports. Each
// port ends in a show-ahead packet buffer. The arbiter grants a port that
// holds a complete packet and forwards that packet word by word, together
// with the packet's receive timestamp and source port id. Malformed first
// words and packets that stall past a cycle budget are discarded or
// terminated, so one bad port cannot lock the shared path.
//
// Configuration macro:
//   ARB_P0_PRIORITY_EN  defined   -> port 0 always wins when it holds a packet
//                       undefined -> round-robin between the two ports
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in TRANS for one packet (11-bit counter)
//
// Ports:
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   iv_pX_data                  buffer head word; bit 8 marks first/last word
//   i_pX_empty                  buffer empty
//   i_pX_pkt_avail              buffer holds at least one complete packet
//   iv_pX_rec_ts                receive timestamp of the packet at the head
//   o_pX_rd                     show-ahead pop strobe (combinational)
//   i_out_stall                 downstream backpressure
//   ov_data, o_data_wr          forwarded word and its valid
//   ov_rec_ts, o_port_id        timestamp and source port of current packet
//   o_timeout_pulse             one-cycle pulse on a timeout abort
//   o_format_err_pulse          one-cycle pulse on a first word without bit 8
//   ov_arb_state                current state (0 IDLE,1 TRANS,2 DRAIN,3 CLOSE)
// ---------------------------------------------------------------------------
module network_rx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 2047
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [8:0]  iv_p0_data,
    input  logic        i_p0_empty,
    input  logic        i_p0_pkt_avail,
    input  logic [18:0] iv_p0_rec_ts,
    output logic        o_p0_rd,
    input  logic [8:0]  iv_p1_data,
    input  logic        i_p1_empty,
    input  logic        i_p1_pkt_avail,
    input  logic [18:0] iv_p1_rec_ts,
    output logic        o_p1_rd,
    input  logic        i_out_stall,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic [18:0] ov_rec_ts,
    output logic        o_port_id,
    output logic        o_timeout_pulse,
    output logic        o_format_err_pulse,
    output logic [1:0]  ov_arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRANS = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLOSE = 2'd3
    } arb_state_e;

    localparam logic [10:0] CYC_LAST = 11'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;

    arb_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [10:0] word_cnt_q, word_cnt_d;
    logic [10:0] cyc_cnt_q, cyc_cnt_d;
    logic [8:0]  data_q, data_d;
    logic        data_wr_q, data_wr_d;
    logic [18:0] rec_ts_q, rec_ts_d;
    logic        port_id_q, port_id_d;
    logic        timeout_q, timeout_d;
    logic        fmt_err_q, fmt_err_d;

    logic        sel_empty_s;
    logic [8:0]  sel_data_s;
    logic [18:0] sel_ts_s;
    logic        pick_s;
    logic        rd_s;

    // Mux the granted port's buffer head onto common signals.
    always_comb begin
        if (grant_q) begin
            sel_empty_s = i_p1_empty;
            sel_data_s  = iv_p1_data;
            sel_ts_s    = iv_p1_rec_ts;
        end else begin
            sel_empty_s = i_p0_empty;
            sel_data_s  = iv_p0_data;
            sel_ts_s    = iv_p0_rec_ts;
        end
    end

    // Choose which port to grant when leaving IDLE.
    always_comb begin
`ifdef ARB_P0_PRIORITY_EN
        if (i_p0_pkt_avail) begin
            pick_s = 1'b0;
        end else begin
            pick_s = 1'b1;
        end
`else
        // With both ports ready, the port that did not finish last wins.
        if (i_p0_pkt_avail && i_p1_pkt_avail) begin
            pick_s = ~last_grant_q;
        end else if (i_p0_pkt_avail) begin
            pick_s = 1'b0;
        end else begin
            pick_s = 1'b1;
        end
`endif
    end

    // Next-state, read strobe and output-register next values.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        data_d       = data_q;
        data_wr_d    = 1'b0;
        rec_ts_d     = rec_ts_q;
        port_id_d    = port_id_q;
        timeout_d    = 1'b0;
        fmt_err_d    = 1'b0;
        rd_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_p0_pkt_avail || i_p1_pkt_avail) begin
                    grant_d    = pick_s;
                    word_cnt_d = 11'd0;
                    cyc_cnt_d  = 11'd0;
                    state_d    = ST_TRANS;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_TRANS: begin
                rd_s      = ~sel_empty_s & ~i_out_stall;
                cyc_cnt_d = cyc_cnt_q + 11'd1;
                if (rd_s && (word_cnt_q == 11'd0) && !sel_data_s[8]) begin
                    // Head is not a packet start: drop it and resynchronise.
                    fmt_err_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (rd_s && (word_cnt_q != 11'd0) && sel_data_s[8]) begin
                    // End word: an end word read in the last budget cycle
                    // still completes the packet normally.
                    data_d       = sel_data_s;
                    data_wr_d    = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    if (rd_s) begin
                        data_d    = sel_data_s;
                        data_wr_d = 1'b1;
                        if (word_cnt_q == 11'd0) begin
                            rec_ts_d  = sel_ts_s;
                            port_id_d = grant_q;
                        end else begin
                            rec_ts_d  = rec_ts_q;
                            port_id_d = port_id_q;
                        end
                        if (word_cnt_q != CNT_MAX) begin
                            word_cnt_d = word_cnt_q + 11'd1;
                        end else begin
                            word_cnt_d = word_cnt_q;
                        end
                    end else begin
                        data_d = data_q;
                    end
                    if (cyc_cnt_q == CYC_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_CLOSE;
                    end else begin
                        state_d   = ST_TRANS;
                    end
                end
            end
            ST_CLOSE: begin
                // Synthetic last word so downstream sees a terminated packet.
                if (!i_out_stall) begin
                    data_d    = {1'b1, 8'h00};
                    data_wr_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    state_d   = ST_CLOSE;
                end
            end
            ST_DRAIN: begin
                // Discarding ignores backpressure: nothing goes downstream.
                rd_s = ~sel_empty_s;
                if (rd_s && sel_data_s[8]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            word_cnt_q   <= 11'd0;
            cyc_cnt_q    <= 11'd0;
            data_q       <= 9'd0;
            data_wr_q    <= 1'b0;
            rec_ts_q     <= 19'd0;
            port_id_q    <= 1'b0;
            timeout_q    <= 1'b0;
            fmt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            data_q       <= data_d;
            data_wr_q    <= data_wr_d;
            rec_ts_q     <= rec_ts_d;
            port_id_q    <= port_id_d;
            timeout_q    <= timeout_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign o_p0_rd            = rd_s & ~grant_q;
    assign o_p1_rd            = rd_s & grant_q;
    assign ov_data            = data_q;
    assign o_data_wr          = data_wr_q;
    assign ov_rec_ts          = rec_ts_q;
    assign o_port_id          = port_id_q;
    assign o_timeout_pulse    = timeout_q;
    assign o_format_err_pulse = fmt_err_q;
    assign ov_arb_state       = state_q;

endmodule

// File: tb/tb_network_rx_arbiter.sv
// Testbench for network_rx_arbiter: show-ahead buffer models on both ports,
// a packet-level arbitration model producing the expected word stream, and a
// monitor that pops the expectation queue whenever o_data_wr is seen.
module tb_network_rx_arbiter;
    localparam int TMO = 160;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [8:0]  p0_data, p1_data;
    logic        p0_empty, p1_empty, p0_avail, p1_avail;
    logic [18:0] p0_ts, p1_ts;
    logic        p0_rd, p1_rd;
    logic        out_stall;
    logic [8:0]  ov_data;
    logic        o_data_wr, o_port_id, o_timeout_pulse, o_format_err_pulse;
    logic [18:0] ov_rec_ts;
    logic [1:0]  ov_arb_state;

    network_rx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .iv_p0_data(p0_data), .i_p0_empty(p0_empty), .i_p0_pkt_avail(p0_avail),
        .iv_p0_rec_ts(p0_ts), .o_p0_rd(p0_rd),
        .iv_p1_data(p1_data), .i_p1_empty(p1_empty), .i_p1_pkt_avail(p1_avail),
        .iv_p1_rec_ts(p1_ts), .o_p1_rd(p1_rd),
        .i_out_stall(out_stall),
        .ov_data(ov_data), .o_data_wr(o_data_wr), .ov_rec_ts(ov_rec_ts),
        .o_port_id(o_port_id), .o_timeout_pulse(o_timeout_pulse),
        .o_format_err_pulse(o_format_err_pulse), .ov_arb_state(ov_arb_state)
    );

    typedef struct packed { logic [8:0] d; logic [18:0] ts; } bword_t;
    typedef struct packed { logic [8:0] d; logic [18:0] ts; logic port; } exp_t;

    bword_t q0[$], q1[$];          // physical buffer contents
    bword_t mw0[$], mw1[$];        // model copy of not-yet-arbitrated packets
    int     len0[$], len1[$];
    bit     bad0[$], bad1[$];
    exp_t   expq[$];
    int     m_last = 1;

    int errors = 0, checks = 0;
    int cyc = 0, mon_cnt = 0, tmo_cnt = 0, fmt_cnt = 0, fmt_cyc = 0;
    int both_rd_err = 0, stall_rd_err = 0, underflow = 0;
    int wr_cycles[$];
    int stall_mode = 0;
    bit chk_stall = 1'b0;
    bit stall_tgl = 1'b0;
    logic rd0_l = 1'b0, rd1_l = 1'b0;

    task automatic refresh();
        p0_empty = (q0.size() == 0);
        p1_empty = (q1.size() == 0);
        p0_avail = ~p0_empty;
        p1_avail = ~p1_empty;
        p0_data  = p0_empty ? 9'h000 : q0[0].d;
        p1_data  = p1_empty ? 9'h000 : q1[0].d;
        p0_ts    = p0_empty ? 19'h0 : q0[0].ts;
        p1_ts    = p1_empty ? 19'h0 : q1[0].ts;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    task automatic add_pkt(input int port, input int len, input bit bad, input logic [18:0] ts);
        bword_t w;
        for (int i = 0; i < len; i++) begin
            if (i == 0) w.d = bad ? 9'h0AA : {1'b1, 8'($urandom)};
            else if (i == len - 1) w.d = {1'b1, 8'($urandom)};
            else w.d = {1'b0, 8'($urandom)};
            w.ts = ts;
            if (port == 0) begin q0.push_back(w); mw0.push_back(w); end
            else begin q1.push_back(w); mw1.push_back(w); end
        end
        if (port == 0) begin len0.push_back(len); bad0.push_back(bad); end
        else begin len1.push_back(len); bad1.push_back(bad); end
    endtask

    // Packet-level arbitration order; bad packets forward nothing.
    task automatic predict();
        int pick, n;
        bit b;
        bword_t w;
        exp_t e;
        while (len0.size() > 0 || len1.size() > 0) begin
`ifdef ARB_P0_PRIORITY_EN
            pick = (len0.size() > 0) ? 0 : 1;
`else
            if (len0.size() > 0 && len1.size() > 0) pick = (m_last == 0) ? 1 : 0;
            else pick = (len0.size() > 0) ? 0 : 1;
`endif
            if (pick == 0) begin n = len0.pop_front(); b = bad0.pop_front(); end
            else begin n = len1.pop_front(); b = bad1.pop_front(); end
            for (int i = 0; i < n; i++) begin
                if (pick == 0) w = mw0.pop_front();
                else w = mw1.pop_front();
                if (!b) begin
                    e.d = w.d; e.ts = w.ts; e.port = (pick == 1);
                    expq.push_back(e);
                end
            end
            m_last = pick;
        end
    endtask

    task automatic drain_wait(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys); #1;
            if (expq.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({nm, "_completed"}, int'(done), 1);
        repeat (4) @(negedge clk_sys);
        @(posedge clk_sys); #2;
    endtask

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        rd0_l = p0_rd;
        rd1_l = p1_rd;
    end

    // Buffer pop after the edge at which the DUT consumed the head word.
    always @(posedge clk_sys) begin
        #1;
        if (reset_n) begin
            if (rd0_l) begin
                if (q0.size() > 0) void'(q0.pop_front());
                else underflow++;
            end
            if (rd1_l) begin
                if (q1.size() > 0) void'(q1.pop_front());
                else underflow++;
            end
        end
        refresh();
    end

    always @(posedge clk_sys) begin
        #1;
        case (stall_mode)
            1: begin stall_tgl = ~stall_tgl; out_stall = stall_tgl; end
            2: out_stall = ($urandom_range(0, 3) == 0);
            default: out_stall = 1'b0;
        endcase
    end

    // Monitor: compare every forwarded word against the expectation queue.
    always @(negedge clk_sys) begin
        exp_t e;
        if (reset_n) begin
            if (p0_rd && p1_rd) both_rd_err++;
            if (chk_stall && out_stall && (p0_rd || p1_rd)) stall_rd_err++;
            if (o_timeout_pulse) tmo_cnt++;
            if (o_format_err_pulse) begin fmt_cnt++; fmt_cyc = cyc; end
            if (o_data_wr) begin
                checks++;
                mon_cnt++;
                wr_cycles.push_back(cyc);
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h ts=%h port=%0d, required no output",
                             ov_data, ov_rec_ts, o_port_id);
                end else begin
                    e = expq.pop_front();
                    if (ov_data !== e.d || ov_rec_ts !== e.ts || o_port_id !== e.port) begin
                        errors++;
                        $display("FAIL word: got data=%h ts=%h port=%0d, required data=%h ts=%h port=%0d",
                                 ov_data, ov_rec_ts, o_port_id, e.d, e.ts, e.port);
                    end
                end
            end
        end
    end

    initial begin
        bword_t w;
        exp_t e;
        int tmo0, fmt0, nbad;
        out_stall = 1'b0;
        refresh();

        // Reset state
        repeat (2) @(negedge clk_sys);
        chk("rst_p0_rd", int'(p0_rd), 0);
        chk("rst_p1_rd", int'(p1_rd), 0);
        chk("rst_data", int'(ov_data), 0);
        chk("rst_wr", int'(o_data_wr), 0);
        chk("rst_ts", int'(ov_rec_ts), 0);
        chk("rst_port", int'(o_port_id), 0);
        chk("rst_pulses", int'({o_timeout_pulse, o_format_err_pulse}), 0);
        chk("rst_state", int'(ov_arb_state), 0);
        @(negedge clk_sys); #1 reset_n = 1'b1;
        m_last = 1;
        @(posedge clk_sys); #2;

        // Two 64-word packets, one gap cycle between them
        wr_cycles.delete();
        add_pkt(0, 64, 1'b0, 19'h00123);
        add_pkt(1, 64, 1'b0, 19'h00456);
        predict();
        refresh();
        drain_wait("two_pkts");
        chk("two_pkts_words", wr_cycles.size(), 128);
        if (wr_cycles.size() == 128) begin
            chk("p0_back_to_back", wr_cycles[63] - wr_cycles[0], 63);
            chk("inter_pkt_gap", wr_cycles[64] - wr_cycles[63], 2);
        end

        // Three packets on port 0, one on port 1
        for (int i = 0; i < 3; i++) add_pkt(0, int'($urandom_range(2, 40)), 1'b0, 19'($urandom));
        add_pkt(1, int'($urandom_range(2, 40)), 1'b0, 19'($urandom));
        predict();
        refresh();
        drain_wait("rr_order");

        // Alternate-cycle stall during a 60-word packet
        tmo0 = tmo_cnt;
        stall_mode = 1;
        chk_stall = 1'b1;
        add_pkt(0, 60, 1'b0, 19'h0ABCD);
        predict();
        refresh();
        drain_wait("stall_pkt");
        stall_mode = 0;
        chk_stall = 1'b0;
        chk("stall_no_rd", stall_rd_err, 0);
        chk("stall_no_timeout", tmo_cnt - tmo0, 0);

        // Port 0 runs dry after word 10 with no end word
        tmo0 = tmo_cnt;
        for (int i = 0; i < 11; i++) begin
            w.d = (i == 0) ? {1'b1, 8'($urandom)} : {1'b0, 8'($urandom)};
            w.ts = 19'h3C0DE;
            q0.push_back(w);
            e.d = w.d; e.ts = w.ts; e.port = 1'b0;
            expq.push_back(e);
        end
        e.d = 9'h100; e.ts = 19'h3C0DE; e.port = 1'b0;
        expq.push_back(e);
        refresh();
        repeat (3) @(posedge clk_sys);
        #2;
        m_last = 0;
        add_pkt(1, 16, 1'b0, 19'h01111);
        predict();
        refresh();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_sys); #1;
            if (tmo_cnt != tmo0) break;
        end
        chk("timeout_pulse", tmo_cnt - tmo0, 1);
        repeat (4) @(negedge clk_sys);
        chk("timeout_drain_state", int'(ov_arb_state), 2);
        @(posedge clk_sys); #2;
        w.ts = 19'h3C0DE;
        w.d = 9'h033; q0.push_back(w);
        w.d = 9'h044; q0.push_back(w);
        w.d = 9'h155; q0.push_back(w);
        refresh();
        drain_wait("timeout");
        chk("timeout_single", tmo_cnt - tmo0, 1);

        // Malformed first word followed by a good packet
        fmt0 = fmt_cnt;
        add_pkt(0, 6, 1'b1, 19'h00BAD);
        add_pkt(0, 12, 1'b0, 19'h00600);
        predict();
        refresh();
        drain_wait("format_err");
        chk("format_err_pulse", fmt_cnt - fmt0, 1);

        // Reset in the middle of a port 0 packet
        mon_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            w.d = (i == 0 || i == 29) ? {1'b1, 8'($urandom)} : {1'b0, 8'($urandom)};
            w.ts = 19'h2A5A5;
            q0.push_back(w);
            if (i < 10) begin
                e.d = w.d; e.ts = w.ts; e.port = 1'b0;
                expq.push_back(e);
            end else begin
                mw0.push_back(w);
            end
        end
        len0.push_back(20);
        bad0.push_back(1'b1);
        refresh();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys); #1;
            if (mon_cnt >= 10) break;
        end
        chk("pre_reset_words", mon_cnt, 10);
        reset_n = 1'b0;
        add_pkt(1, 20, 1'b0, 19'h07777);
        m_last = 1;
        predict();
        refresh();
        @(negedge clk_sys);
        chk("mid_rst_rd", int'({p0_rd, p1_rd}), 0);
        chk("mid_rst_data_wr", int'({ov_data, o_data_wr}), 0);
        chk("mid_rst_ts_port", int'({ov_rec_ts, o_port_id}), 0);
        chk("mid_rst_state", int'(ov_arb_state), 0);
        repeat (2) @(negedge clk_sys);
        fmt0 = fmt_cnt;
        wr_cycles.delete();
        #1 reset_n = 1'b1;
        drain_wait("after_reset");
        chk("after_reset_fmt_err", fmt_cnt - fmt0, 1);
        chk("p0_wins_after_reset",
            (wr_cycles.size() > 0 && fmt_cyc < wr_cycles[0]) ? 1 : 0, 1);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            tmo0 = tmo_cnt;
            fmt0 = fmt_cnt;
            nbad = 0;
            stall_mode = int'($urandom_range(0, 2));
            for (int p = 0; p < 2; p++) begin
                int n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) begin
                    bit b = ($urandom_range(0, 5) == 0);
                    if (b) nbad++;
                    add_pkt(p, int'($urandom_range(2, 40)), b, 19'($urandom));
                end
            end
            predict();
            refresh();
            drain_wait("random_round");
            chk("random_fmt_errs", fmt_cnt - fmt0, nbad);
            chk("random_no_timeout", tmo_cnt - tmo0, 0);
        end
        stall_mode = 0;

        chk("single_rd", both_rd_err, 0);
        chk("no_underflow", underflow, 0);
        chk("exp_queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
